// File: rtl/alu_pkg.sv
// Shared definitions for alu_seq: op codes and the control state encoding.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_nbit.sv
// WIDTH-bit add/subtract: subtraction is a + ~b + 1 through the same carry chain.
// Overflow is the signed overflow of the effective (possibly inverted) operands.
module addsub_nbit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_full;

  assign w_b    = i_b ^ {WIDTH{i_sub}};
  assign w_full = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_sub};
  assign o_sum  = w_full[WIDTH-1:0];
  assign o_cout = w_full[WIDTH];
  assign o_ovf  = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result/flags behind a valid/ready pair.
// Define ALU_MUL_EN to enable the iterative shift-add multiply (op 110); otherwise 110 is reserved.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_r1,
  input  logic [WIDTH-1:0] i_r2,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_busy
);

  state_t           r_state, w_state_d;
  logic [WIDTH-1:0] r_result, w_res_new;
  logic             r_carry, r_ovf, r_zero;
  logic             w_carry_new, w_ovf_new, w_load;

  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout, w_ovf, w_slt;

  // One adder serves ADD, SUB and SLT straight from the presented operands.
  assign w_sub = (i_op != OP_ADD);

  addsub_nbit #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .i_a   (i_r1),
    .i_b   (i_r2),
    .i_sub (w_sub),
    .o_sum (w_sum),
    .o_cout(w_cout),
    .o_ovf (w_ovf)
  );

  assign w_slt = w_sum[WIDTH-1] ^ w_ovf;

`ifdef ALU_MUL_EN
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_acc, r_mcand, w_addend, w_acc_sum;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               w_accept, w_mul_last;
  logic               w_mul_cout, w_mul_ovf, w_unused_mul;

  assign w_accept   = (r_state == IDLE) && i_in_valid;
  assign w_mul_last = (r_cnt == CW'(WIDTH));
  assign w_addend   = r_mplier[0] ? r_mcand : '0;

  addsub_nbit #(
    .WIDTH(2 * WIDTH)
  ) u_mul_add (
    .i_a   (r_acc),
    .i_b   (w_addend),
    .i_sub (1'b0),
    .o_sum (w_acc_sum),
    .o_cout(w_mul_cout),
    .o_ovf (w_mul_ovf)
  );

  // The product always fits in 2*WIDTH bits, so the wide adder's flags carry no information.
  assign w_unused_mul = w_mul_cout ^ w_mul_ovf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_r1};
      r_mplier <= i_r2;
      r_cnt    <= '0;
    end else if ((r_state == EXEC) && !w_mul_last) begin
      r_acc    <= w_acc_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end
`endif

  always_comb begin
    w_state_d   = r_state;
    w_load      = 1'b0;
    w_res_new   = '0;
    w_carry_new = 1'b0;
    w_ovf_new   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          w_state_d = DONE;
          w_load    = 1'b1;
          case (i_op)
            OP_ADD, OP_SUB: begin
              w_res_new   = w_sum;
              w_carry_new = w_cout;
              w_ovf_new   = w_ovf;
            end
            OP_AND: w_res_new = i_r1 & i_r2;
            OP_OR:  w_res_new = i_r1 | i_r2;
            OP_XOR: w_res_new = i_r1 ^ i_r2;
            OP_SLT: w_res_new = {{(WIDTH - 1){1'b0}}, w_slt};
`ifdef ALU_MUL_EN
            OP_MUL: begin
              w_state_d = EXEC;
              w_load    = 1'b0;
            end
`endif
            default: w_res_new = '0;
          endcase
        end
      end
`ifdef ALU_MUL_EN
      // One extra EXEC cycle after the last multiplier bit registers the product.
      EXEC: begin
        if (w_mul_last) begin
          w_state_d   = DONE;
          w_load      = 1'b1;
          w_res_new   = r_acc[WIDTH-1:0];
          w_carry_new = |r_acc[2*WIDTH-1:WIDTH];
        end
      end
`endif
      DONE: begin
        if (i_out_ready) begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_load) begin
        r_result <= w_res_new;
        r_carry  <= w_carry_new;
        r_ovf    <= w_ovf_new;
        r_zero   <= (w_res_new == '0);
      end
    end
  end

  assign o_in_ready  = (r_state == IDLE);
  assign o_out_valid = (r_state == DONE);
  assign o_busy      = (r_state != IDLE);
  assign o_result    = r_result;
  assign o_carry     = r_carry;
  assign o_overflow  = r_ovf;
  assign o_zero      = r_zero;

endmodule
